// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
//   uart_state_e   : transmitter FSM states
//   UART_START_LVL : line level driven during the start bit
//   UART_STOP_LVL  : line level driven during the stop bit and when idle
//   UART_DATA_BITS : payload bits per frame (8N1)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter for the UART transmitter.
// Counts 0..CLK_DIV-1 and wraps; held at 0 while i_restart is high.
//   i_clk      : system clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_restart  : clears the counter (held high outside timed states)
//   o_tick     : high on the last cycle of a bit period (count CLK_DIV-1)
//   o_pre_tick : high one cycle before o_tick (count CLK_DIV-2), lets the
//                owner register an output that lands on the last cycle
module uart_baud_cnt #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned CNT_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick     = (r_cnt == LAST_CNT);
  assign o_pre_tick = (r_cnt == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a 4-entry byte FIFO and sends each as an
// 8N1 UART frame, LSB first. All outputs are registered.
//   CLK              : system clock, rising edge
//   UARTTX_RST       : synchronous active-high reset
//   UARTTX_EN        : level, permits starting new frames (sampled in IDLE)
//   FIFO_EMPTYSignal : FIFO empty flag
//   FIFO_DataOut     : FIFO read data, valid the cycle after FIFO_RD
//   FIFO_RD          : one-cycle pop strobe
//   UARTTX_TXD       : serial line, idle high
//   UARTTX_BUSY      : high from POP through the end of STOP
//   UARTTX_DONE      : one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       CLK,
  input  logic       UARTTX_RST,
  input  logic       UARTTX_EN,
  input  logic       FIFO_EMPTYSignal,
  input  logic [7:0] FIFO_DataOut,
  output logic       FIFO_RD,
  output logic       UARTTX_TXD,
  output logic       UARTTX_BUSY,
  output logic       UARTTX_DONE
);

  uart_state_e                     r_state;
  logic [UART_DATA_BITS-1:0]       r_shreg;
  logic [2:0]                      r_bit_idx;
  logic                            r_rd;
  logic                            r_txd;
  logic                            r_busy;
  logic                            r_done;
  logic                            w_restart;
  logic                            w_tick;
  logic                            w_pre_tick;

  // Counter is held at 0 in the untimed states, so it starts from 0 on
  // entry to START; each later bit-period boundary is its natural wrap.
  assign w_restart = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_baud_cnt (
    .i_clk      (CLK),
    .i_rst      (UARTTX_RST),
    .i_restart  (w_restart),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick)
  );

  always_ff @(posedge CLK) begin
    if (UARTTX_RST) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_rd      <= 1'b0;
      r_txd     <= UART_STOP_LVL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (UARTTX_EN && !FIFO_EMPTYSignal) begin
            r_state <= POP;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        POP: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_shreg <= FIFO_DataOut;
          r_txd   <= UART_START_LVL;
          r_state <= START;
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_txd     <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            // TXD is registered, so drive the next bit (shreg[1]) together
            // with the shift rather than waiting a cycle for shreg[0].
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
              r_state <= STOP;
              r_txd   <= UART_STOP_LVL;
            end else begin
              r_txd <= r_shreg[1];
            end
          end
        end
        STOP: begin
          if (w_pre_tick) begin
            r_done <= 1'b1;
          end
          if (w_tick) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign FIFO_RD     = r_rd;
  assign UARTTX_TXD  = r_txd;
  assign UARTTX_BUSY = r_busy;
  assign UARTTX_DONE = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with
// CLK_DIV=4. A small queue models the FIFO (registered read data, empty flag).
module tb_fifo_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       EMPTY = 1'b1;
  logic [7:0] DOUT = '0;
  logic       RD;
  logic       TXD;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int bad_pop = 0;
  byte unsigned q[$];

  fifo_uart_tx #(
    .CLK_DIV (4),
    .CNT_W   (16)
  ) dut (
    .CLK              (CLK),
    .UARTTX_RST       (RST),
    .UARTTX_EN        (EN),
    .FIFO_EMPTYSignal (EMPTY),
    .FIFO_DataOut     (DOUT),
    .FIFO_RD          (RD),
    .UARTTX_TXD       (TXD),
    .UARTTX_BUSY      (BUSY),
    .UARTTX_DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input byte unsigned b);
    q.push_back(b);
    EMPTY = 1'b0;
  endtask

  // One clock: sample the pop strobe seen by the edge, then update the model.
  task automatic step();
    logic rd_prev;
    rd_prev = RD;
    @(posedge CLK);
    #1;
    if (rd_prev === 1'b1) begin
      rd_cnt++;
      if (q.size() == 0) bad_pop++;
      else DOUT = q.pop_front();
    end
    EMPTY = (q.size() == 0);
    if (DONE === 1'b1) done_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (TXD !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_start"}, 32'(TXD), 32'(0));
  endtask

  // Observes one 40-cycle frame from the first start-bit cycle to the last
  // stop-bit cycle. exp[i] is the line level of bit slot i (0 = start).
  task automatic capture(input string tag, input logic [9:0] exp, input int drop_off);
    logic [9:0] mid;
    int         done_at;
    bit         shape_ok;
    int         d0;
    wait_start(tag);
    mid      = '0;
    done_at  = -1;
    shape_ok = 1'b1;
    d0       = done_cnt;
    for (int off = 0; off < 40; off++) begin
      if (off == drop_off) EN = 1'b0;
      if (TXD !== exp[off/4] || BUSY !== 1'b1) shape_ok = 1'b0;
      if (off % 4 == 2) mid[off/4] = TXD;
      if (DONE === 1'b1 && done_at < 0) done_at = off;
      if (off < 39) step();
    end
    chk({tag, "_bits"}, 32'(mid), 32'(exp));
    chk({tag, "_every_cycle"}, 32'(shape_ok), 32'(1));
    chk({tag, "_done_at"}, 32'(done_at), 32'(39));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
  endtask

  initial begin
    int rd0;
    int d0;
    int lows;
    int busy_hi;
    int hi;

    // Reset with a byte waiting and enable high.
    EN = 1'b1;
    push(8'hA5);
    RST = 1'b1;
    step();
    chk("rst_cycle1", 32'({TXD, RD, BUSY, DONE}), 32'(4'b1000));
    step();
    chk("rst_cycle2", 32'({TXD, RD, BUSY, DONE}), 32'(4'b1000));
    RST = 1'b0;

    // Single byte 0xA5: pop one cycle after release, start bit two later.
    step();
    chk("pop_after_release", 32'({TXD, RD, BUSY}), 32'(3'b111));
    step();
    chk("load_cycle", 32'({TXD, RD, BUSY}), 32'(3'b101));
    step();
    chk("start_latency", 32'({TXD, RD, BUSY}), 32'(3'b001));
    capture("a5", 10'b1101001010, -1);
    chk("a5_rd_pulses", 32'(rd_cnt), 32'(1));

    // Empty FIFO with enable high: nothing happens.
    rd0 = rd_cnt; lows = 0; busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (TXD !== 1'b1) lows++;
      if (BUSY !== 1'b0) busy_hi++;
    end
    chk("empty_no_rd", 32'(rd_cnt - rd0), 32'(0));
    chk("empty_txd_high", 32'(lows), 32'(0));
    chk("empty_not_busy", 32'(busy_hi), 32'(0));

    // Back-to-back 0x00 then 0xFF: 3 idle-high cycles between frames.
    rd0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    capture("b2b_00", 10'b1000000000, -1);
    hi = 0;
    step();
    while (TXD === 1'b1 && hi < 20) begin
      hi++;
      step();
    end
    chk("b2b_gap", 32'(hi), 32'(3));
    capture("b2b_ff", 10'b1111111110, -1);
    chk("b2b_rd_pulses", 32'(rd_cnt - rd0), 32'(2));

    // Enable dropped during data bit 3 of 0x3C with a second byte queued.
    rd0 = rd_cnt;
    push(8'h3C);
    push(8'h81);
    capture("en_3c", 10'b1001111000, 16);
    lows = 0; busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (TXD !== 1'b1) lows++;
      if (BUSY !== 1'b0) busy_hi++;
    end
    chk("en_low_rd", 32'(rd_cnt - rd0), 32'(1));
    chk("en_low_txd", 32'(lows), 32'(0));
    chk("en_low_busy", 32'(busy_hi), 32'(0));
    EN = 1'b1;
    step();
    chk("en_resume_rd", 32'(RD), 32'(1));
    capture("en_81", 10'b1100000010, -1);
    chk("en_rd_pulses", 32'(rd_cnt - rd0), 32'(2));

    // Reset during data bit 5 of 0xA5, then a fresh frame of 0x96.
    push(8'hA5);
    wait_start("rmf_a5");
    steps(25);
    chk("rmf_mid_busy", 32'({TXD === 1'bx, BUSY}), 32'(2'b01));
    rd0 = rd_cnt;
    d0 = done_cnt;
    RST = 1'b1;
    step();
    chk("rmf_reset_edge", 32'({TXD, RD, BUSY, DONE}), 32'(4'b1000));
    push(8'h96);
    step();
    chk("rmf_reset_hold", 32'({TXD, RD, BUSY, DONE}), 32'(4'b1000));
    RST = 1'b0;
    step();
    chk("rmf_fresh_pop", 32'(RD), 32'(1));
    chk("rmf_no_done", 32'(done_cnt - d0), 32'(0));
    capture("rmf_96", 10'b1100101100, -1);
    chk("rmf_rd_pulses", 32'(rd_cnt - rd0), 32'(1));

    chk("no_pop_when_empty", 32'(bad_pop), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
